// File: rtl/dcc_frame_ctrl.sv
// Double-buffered 32x32 detector frame publisher with HPS toggle handshake and a PPS timebase.
// Idle-timeout partial flush is compiled in only when DCC_FRAME_TIMEOUT_EN is defined.
module dcc_frame_ctrl #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          evt_valid,
  input  logic [31:0]   evt_data,
  output logic          evt_ready,
  output logic [1023:0] frame_data,
  output logic [5:0]    frame_words,
  output logic          frame_seq,
  input  logic          hps_read_bit,
  input  logic          pps_in,
  output logic [25:0]   time_out,
  output logic [31:0]   pps_count
);
  localparam int NUM_WORDS = 32;
  localparam int VEC_W     = 32;

  typedef enum logic {FILL, WAIT_SWAP} state_t;
  state_t state, state_nxt;

  logic [NUM_WORDS-1:0][VEC_W-1:0] fill_buf, frame_q, frame_nxt;
  logic [5:0] fill_cnt;
  logic       xfer, out_free, swap, flush;

  assign evt_ready  = (state == FILL) && !reset_reset;
  assign xfer       = evt_valid && evt_ready;
  assign out_free   = (hps_read_bit == frame_seq);
  assign frame_data = frame_q;

`ifdef DCC_FRAME_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IW-1:0] idle_cnt;

  // A transfer in the expiry cycle wins: no flush, counter restarts.
  assign flush = (state == FILL) && !xfer && (fill_cnt != 6'd0) &&
                 (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset)                                  idle_cnt <= '0;
    else if (xfer || fill_cnt == 6'd0 || state != FILL) idle_cnt <= '0;
    else                                              idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign flush          = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      FILL:
        if ((xfer && fill_cnt == 6'd31) || flush) state_nxt = WAIT_SWAP;
      WAIT_SWAP:
        if (out_free) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= FILL;
    else             state <= state_nxt;
  end

  // Fill buffer needs no reset: fill_cnt masks anything stale at publish time.
  always_ff @(posedge clk_clk) begin
    if (xfer) fill_buf[fill_cnt[4:0]] <= evt_data;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset || swap) fill_cnt <= 6'd0;
    else if (xfer)           fill_cnt <= fill_cnt + 6'd1;
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign frame_nxt[k] = (6'(k) < fill_cnt) ? fill_buf[k] : '0;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      frame_q     <= '0;
      frame_words <= 6'd0;
      frame_seq   <= 1'b0;
    end else if (swap) begin
      frame_q     <= frame_nxt;
      frame_words <= fill_cnt;
      frame_seq   <= ~frame_seq;
    end
  end

  // PPS: two-flop synchronizer, then a third flop for rising-edge detect.
  logic pps_s1, pps_s2, pps_s3, pps_edge;
  assign pps_edge = pps_s2 && !pps_s3;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pps_s1    <= 1'b0;
      pps_s2    <= 1'b0;
      pps_s3    <= 1'b0;
      time_out  <= '0;
      pps_count <= '0;
    end else begin
      pps_s1 <= pps_in;
      pps_s2 <= pps_s1;
      pps_s3 <= pps_s2;
      if (pps_edge) begin
        time_out  <= '0;
        pps_count <= pps_count + 32'd1;
      end else if (time_out != '1) begin
        time_out  <= time_out + 26'd1;
      end
    end
  end
endmodule

// File: tb/tb_dcc_frame_ctrl.sv
// Directed bench for dcc_frame_ctrl; timeout scenarios run when DCC_FRAME_TIMEOUT_EN is defined.
module tb_dcc_frame_ctrl;
  logic          clk_clk = 1'b0;
  logic          reset_reset, evt_valid, evt_ready, frame_seq, hps_read_bit, pps_in;
  logic [31:0]   evt_data, pps_count;
  logic [1023:0] frame_data;
  logic [5:0]    frame_words;
  logic [25:0]   time_out;

  int n_checks = 0;
  int n_fail   = 0;

  dcc_frame_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_ready(evt_ready), .frame_data(frame_data),
    .frame_words(frame_words), .frame_seq(frame_seq), .hps_read_bit(hps_read_bit),
    .pps_in(pps_in), .time_out(time_out), .pps_count(pps_count));

  always #5 clk_clk = ~clk_clk;

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int k);
    return frame_data[32*k +: 32];
  endfunction

  task automatic send(input logic [31:0] d);
    evt_valid = 1'b1;
    evt_data  = d;
    step();
    evt_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1; evt_valid = 1'b0; evt_data = '0; hps_read_bit = 1'b0; pps_in = 1'b0;
    repeat (3) step();
    n_checks++; if (evt_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", evt_ready); end
    n_checks++; if (frame_data !== '0) begin n_fail++; $display("FAIL rst_frame got nonzero want 0"); end
    n_checks++; if (frame_words !== 6'd0) begin n_fail++; $display("FAIL rst_words got %0d want 0", frame_words); end
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL rst_seq got %b want 0", frame_seq); end
    n_checks++; if (time_out !== 26'd0) begin n_fail++; $display("FAIL rst_time got %0d want 0", time_out); end
    n_checks++; if (pps_count !== 32'd0) begin n_fail++; $display("FAIL rst_pps got %0d want 0", pps_count); end
    reset_reset = 1'b0;
    #1;
    n_checks++; if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b want 1", evt_ready); end
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < 32; k++) send(32'h100 + k);
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL ff_seq_early got %b want 0", frame_seq); end
    n_checks++; if (evt_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ready got %b want 0", evt_ready); end
    step();
    n_checks++; if (frame_seq !== 1'b1) begin n_fail++; $display("FAIL ff_seq got %b want 1", frame_seq); end
    n_checks++; if (frame_words !== 6'd32) begin n_fail++; $display("FAIL ff_words got %0d want 32", frame_words); end
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (word(k) !== 32'h100 + k) begin n_fail++; $display("FAIL ff_word%0d got %h want %h", k, word(k), 32'h100 + k); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 32; k++) send(32'h120 + k);
    repeat (5) step();
    n_checks++; if (evt_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", evt_ready); end
    n_checks++; if (frame_seq !== 1'b1) begin n_fail++; $display("FAIL bp_seq got %b want 1", frame_seq); end
    n_checks++; if (word(0) !== 32'h100) begin n_fail++; $display("FAIL bp_hold got %h want 100", word(0)); end
    hps_read_bit = 1'b1;
    step();
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL bp_seq2 got %b want 0", frame_seq); end
    n_checks++; if (word(0) !== 32'h120) begin n_fail++; $display("FAIL bp_w0 got %h want 120", word(0)); end
    n_checks++; if (word(31) !== 32'h13F) begin n_fail++; $display("FAIL bp_w31 got %h want 13f", word(31)); end
    n_checks++; if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready2 got %b want 1", evt_ready); end
  endtask

  task automatic test_pps();
    for (int c = 0; c < 1003; c++) begin
      pps_in = (c < 5) || (c >= 1000 && c < 1005);
      step();
      if (c == 2) begin
        n_checks++; if (time_out !== 26'd0) begin n_fail++; $display("FAIL pps_t0 got %0d want 0", time_out); end
        n_checks++; if (pps_count !== 32'd1) begin n_fail++; $display("FAIL pps_c1 got %0d want 1", pps_count); end
      end
      if (c == 1001) begin
        n_checks++; if (time_out !== 26'd999) begin n_fail++; $display("FAIL pps_t999 got %0d want 999", time_out); end
        n_checks++; if (pps_count !== 32'd1) begin n_fail++; $display("FAIL pps_once got %0d want 1", pps_count); end
      end
      if (c == 1002) begin
        n_checks++; if (time_out !== 26'd0) begin n_fail++; $display("FAIL pps_t0b got %0d want 0", time_out); end
        n_checks++; if (pps_count !== 32'd2) begin n_fail++; $display("FAIL pps_c2 got %0d want 2", pps_count); end
      end
    end
    pps_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) send(32'h1A0 + k);
    reset_reset = 1'b1;
    step();
    n_checks++; if (frame_data !== '0) begin n_fail++; $display("FAIL mid_frame got nonzero want 0"); end
    n_checks++; if (frame_words !== 6'd0) begin n_fail++; $display("FAIL mid_words got %0d want 0", frame_words); end
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL mid_seq got %b want 0", frame_seq); end
    n_checks++; if (time_out !== 26'd0) begin n_fail++; $display("FAIL mid_time got %0d want 0", time_out); end
    n_checks++; if (pps_count !== 32'd0) begin n_fail++; $display("FAIL mid_pps got %0d want 0", pps_count); end
    n_checks++; if (evt_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0", evt_ready); end
    hps_read_bit = 1'b0;
    reset_reset  = 1'b0;
    #1;
    n_checks++; if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel got %b want 1", evt_ready); end
    repeat (40) step();
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL mid_nopub got %b want 0", frame_seq); end
    for (int k = 0; k < 32; k++) send(32'h200 + k);
    step();
    n_checks++; if (frame_seq !== 1'b1) begin n_fail++; $display("FAIL mid_seq2 got %b want 1", frame_seq); end
    n_checks++; if (word(0) !== 32'h200) begin n_fail++; $display("FAIL mid_w0 got %h want 200", word(0)); end
    n_checks++; if (frame_words !== 6'd32) begin n_fail++; $display("FAIL mid_words2 got %0d want 32", frame_words); end
  endtask

`ifdef DCC_FRAME_TIMEOUT_EN
  task automatic test_timeout_flush();
    hps_read_bit = 1'b1;
    for (int k = 0; k < 3; k++) send(32'h300 + k);
    repeat (16) step();
    n_checks++; if (frame_seq !== 1'b1) begin n_fail++; $display("FAIL to_early got %b want 1", frame_seq); end
    n_checks++; if (evt_ready !== 1'b0) begin n_fail++; $display("FAIL to_ready got %b want 0", evt_ready); end
    step();
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL to_seq got %b want 0", frame_seq); end
    n_checks++; if (frame_words !== 6'd3) begin n_fail++; $display("FAIL to_words got %0d want 3", frame_words); end
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (word(k) !== ((k < 3) ? 32'h300 + k : 32'd0)) begin
        n_fail++; $display("FAIL to_word%0d got %h want %h", k, word(k), (k < 3) ? 32'h300 + k : 32'd0);
      end
    end
  endtask

  task automatic test_timeout_race();
    hps_read_bit = 1'b0;
    send(32'h400);
    repeat (15) step();
    send(32'h401);
    n_checks++; if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL race_ready got %b want 1", evt_ready); end
    repeat (16) step();
    n_checks++; if (frame_seq !== 1'b0) begin n_fail++; $display("FAIL race_early got %b want 0", frame_seq); end
    step();
    n_checks++; if (frame_seq !== 1'b1) begin n_fail++; $display("FAIL race_seq got %b want 1", frame_seq); end
    n_checks++; if (frame_words !== 6'd2) begin n_fail++; $display("FAIL race_words got %0d want 2", frame_words); end
    n_checks++; if (word(1) !== 32'h401) begin n_fail++; $display("FAIL race_w1 got %h want 401", word(1)); end
    n_checks++; if (word(2) !== 32'h0) begin n_fail++; $display("FAIL race_w2 got %h want 0", word(2)); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_pps();
    test_reset_mid();
`ifdef DCC_FRAME_TIMEOUT_EN
    test_timeout_flush();
    test_timeout_race();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcc_frame_ctrl.md
DCC_FRAME_CTRL -- requirements
Module: dcc_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000, is the number of idle cycles after which a partial frame is flushed.
REQ-002 Port clk_clk, input, 1 bit: the only clock; every register is clocked on its rising edge.
REQ-003 Port reset_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port evt_valid, input, 1 bit: the upstream detector word is valid.
REQ-005 Port evt_data, input, 32 bits: the detector word.
REQ-006 Port evt_ready, output, 1 bit: the block accepts evt_data; a transfer occurs when evt_valid and evt_ready are both 1.
REQ-007 Port frame_data, output, 1024 bits: the published frame; word k sits at bits [32k+31:32k] and drives dcc_data_k.
REQ-008 Port frame_words, output, 6 bits: the number of valid words in the published frame, 1..32.
REQ-009 Port frame_seq, output, 1 bit: the publish toggle, exported alongside the frame.
REQ-010 Port hps_read_bit, input, 1 bit: the HPS ack; the HPS writes it equal to frame_seq once it has consumed the frame.
REQ-011 Port pps_in, input, 1 bit: the asynchronous GPS PPS pulse.
REQ-012 Port time_out, output, 26 bits: the clock count since the last PPS edge; drives dcc_time_out.
REQ-013 Port pps_count, output, 32 bits: the number of PPS rising edges seen since reset.

Function
REQ-014 The block holds two 32x32 buffers: the fill buffer and the published buffer (frame_data).
REQ-015 The FSM has two states: FILL and WAIT_SWAP.
REQ-016 evt_ready is 1 only in FILL.
REQ-017 Each transfer writes fill[fill_cnt] and then increments fill_cnt (6 bits).
REQ-018 The FSM goes FILL->WAIT_SWAP on the transfer that makes fill_cnt equal 32.
REQ-019 out_free is 1 when hps_read_bit equals frame_seq.
REQ-020 In WAIT_SWAP with out_free=1, one edge does all of the following: copy fill into frame_data, with words at index fill_cnt or above forced to 0; set frame_words to fill_cnt; invert frame_seq; clear fill_cnt; return to FILL.
REQ-021 In WAIT_SWAP with out_free=0, the FSM holds, evt_ready stays 0 and the fill buffer is unchanged.
REQ-022 Latency: if the 32nd word is accepted at edge E and out_free=1, the new frame_data, frame_words and frame_seq are visible after edge E+1.
REQ-023 The idle counter clears on every transfer, and on every cycle that fill_cnt is 0.
REQ-024 Otherwise the idle counter increments while in FILL.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES-1 with fill_cnt of 1 or more, the FSM goes FILL->WAIT_SWAP (partial flush).
REQ-026 If a transfer and timeout expiry fall in the same cycle, the transfer wins: the word is stored, the idle counter clears and no flush occurs.
REQ-027 frame_data never changes except at a swap edge, so the HPS always reads a stable frame.
REQ-028 pps_in passes through a 2-flop synchronizer followed by a rising-edge detect.
REQ-029 On a detected PPS edge, time_out loads 0 and pps_count increments; pps_count wraps from 0xFFFFFFFF to 0.
REQ-030 On any other cycle, time_out increments and saturates at 0x3FFFFFF.
REQ-031 No event is ever dropped; back-pressure is applied only through evt_ready.

Reset
REQ-032 While reset_reset is 1 at an edge, all of the following load: state FILL; fill_cnt 0; idle counter 0; frame_data all zero; frame_words 0; frame_seq 0; time_out 0; pps_count 0; synchronizer flops 0.
REQ-033 evt_ready is 0 while reset_reset is 1.
REQ-034 Reset mid-frame discards the fill buffer contents; no partial frame is published.
REQ-035 After reset, frame_seq=0 and the HPS reset value hps_read_bit=0, so out_free=1.

Configuration
REQ-036 With macro DCC_FRAME_TIMEOUT_EN defined, the idle counter and partial flush of REQ-023 to REQ-026 are compiled in.
REQ-037 With DCC_FRAME_TIMEOUT_EN undefined, the idle counter is absent, only full 32-word frames are published, and frame_words is always 32 after the first swap.

Verification
REQ-038 Reset, then 32 back-to-back words 0x100..0x11F with hps_read_bit=0 -> word k=0x100+k, frame_words=32 and frame_seq=1 one cycle after the last accept.
REQ-039 Hold hps_read_bit=0 after the first frame and send 32 more words -> evt_ready=0 after the 64th word, frame_data unchanged; set hps_read_bit=1 -> swap next edge, frame_seq=0, word 0=0x120.
REQ-040 (DCC_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16) Send 3 words then idle -> flush after 16 idle cycles, frame_words=3, words 3..31=0.
REQ-041 (DCC_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16) A word arrives on the expiry cycle -> no flush, fill_cnt increments, idle restarts.
REQ-042 Pulse pps_in for 5 cycles, 1000 cycles apart -> pps_count increments once per pulse; time_out reads 0 three edges after the pps_in rise and 999 just before the next reset to 0.
REQ-043 Assert reset_reset after 10 of 32 words -> all outputs 0, evt_ready=1 on the cycle after reset releases, no frame published.
